keypad_scan_debounce: RTL

//  Scans a 3-column x 4-row matrix keypad and debounces the result. Reports single-key presses as one-cycle event

---
 rtl/keypad_scan_debounce_if.sv | 21 ++
 rtl/keypad_scan_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce_if.sv
// Keypad pin and key-event bundle shared by the scanner (master) and its
// consumers (slave): row sense in, column drive and key events out.
interface keypad_scan_debounce_if;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_star_rise;
  logic       key_pound_rise;

  modport master (
    input  key_row,
    output key_col, key_code, key_valid, key_held, key_star_rise, key_pound_rise
  );

  modport slave (
    output key_row,
    input  key_col, key_code, key_valid, key_held, key_star_rise, key_pound_rise
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 3x4 matrix keypad scanner: column drive, row synchronizer, per-frame
// single-contact decode, frame debounce and a press/release FSM with event pulses.
module keypad_scan_debounce #(
  parameter int SCAN_TICKS     = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  keypad_scan_debounce_if.master kp
);

  localparam int                TICK_W     = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
  localparam logic [3:0]        DEB_MAX    = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0]        CODE_NONE  = 4'hF;
  localparam logic [3:0]        CODE_STAR  = 4'hA;
  localparam logic [3:0]        CODE_POUND = 4'hB;

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } state_e;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b11_00: code = CODE_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = CODE_POUND;
      default:  code = CODE_NONE;
    endcase
    return code;
  endfunction

  logic [3:0]        row_s1_q, row_s2_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        hits_q, hits_d;
  logic [3:0]        hit_code_q, hit_code_d;
  logic [3:0]        frame_code;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        stable_cnt_q, stable_cnt_d;
  logic [3:0]        deb_q, deb_d;
  state_e            state_q, state_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              star_q, star_d;
  logic              pound_q, pound_d;
  logic              last_tick, frame_end;

  assign last_tick = (tick_q == TICK_LAST);
  assign frame_end = last_tick && (col_idx_q == 2'd2);

  // Column scan timing runs free, independent of key activity.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    tick_d    = tick_q + TICK_W'(1);
    col_idx_d = col_idx_q;
    if (last_tick) begin
      tick_d    = '0;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    end
  end

  // Contact accumulation over one frame; the count saturates at 2 so any
  // multi-key or ghost pattern collapses to "none".
  always_comb begin
    // NOTE: blocking assignments here let later loop iterations see the running count; state flops still use <=.
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    frame_code = CODE_NONE;
    if (last_tick) begin
      for (int r = 0; r < 4; r++) begin
        if (row_s2_q[r]) begin
          if (hits_d == 2'd0) hit_code_d = key_map(2'(r), col_idx_q);
          if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
        end
      end
      frame_code = (hits_d == 2'd1) ? hit_code_d : CODE_NONE;
      if (frame_end) begin
        hits_d     = '0;
        hit_code_d = CODE_NONE;
      end
    end
  end

  always_comb begin
    cand_d       = cand_q;
    stable_cnt_d = stable_cnt_q;
    deb_d        = deb_q;
    if (frame_end) begin
      if (frame_code == cand_q) begin
        if (stable_cnt_q != DEB_MAX) begin
          stable_cnt_d = stable_cnt_q + 4'd1;
          if (stable_cnt_d == DEB_MAX) deb_d = cand_q;
        end
      end else begin
        cand_d       = frame_code;
        stable_cnt_d = 4'd1;
        if (DEB_MAX == 4'd1) deb_d = frame_code;
      end
    end
  end

  // A new press is only taken from IDLE, so a different key appearing while
  // one is held is ignored until a debounced release is seen.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    star_d      = 1'b0;
    pound_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (deb_q != CODE_NONE) begin
          state_d     = ST_PRESSED;
          key_valid_d = 1'b1;
          key_code_d  = deb_q;
          key_held_d  = 1'b1;
          star_d      = (deb_q == CODE_STAR);
          pound_d     = (deb_q == CODE_POUND);
        end
      end
      ST_PRESSED: begin
        if (deb_q == CODE_NONE) begin
          state_d    = ST_IDLE;
          key_held_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      tick_q       <= '0;
      col_idx_q    <= '0;
      hits_q       <= '0;
      hit_code_q   <= CODE_NONE;
      cand_q       <= CODE_NONE;
      stable_cnt_q <= '0;
      deb_q        <= CODE_NONE;
      state_q      <= ST_IDLE;
      key_code_q   <= CODE_NONE;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      star_q       <= 1'b0;
      pound_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      row_s1_q     <= kp.key_row;
      row_s2_q     <= row_s1_q;
      tick_q       <= tick_d;
      col_idx_q    <= col_idx_d;
      hits_q       <= hits_d;
      hit_code_q   <= hit_code_d;
      cand_q       <= cand_d;
      stable_cnt_q <= stable_cnt_d;
      deb_q        <= deb_d;
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      star_q       <= star_d;
      pound_q      <= pound_d;
    end
  end

  assign kp.key_col        = 3'b001 << col_idx_q;
  assign kp.key_code       = key_code_q;
  assign kp.key_valid      = key_valid_q;
  assign kp.key_held       = key_held_q;
  assign kp.key_star_rise  = star_q;
  assign kp.key_pound_rise = pound_q;

endmodule
